branch_predict_unit: RTL and testbench

- Parametrised successor to the combinational branch decision logic.
- Two jobs:
  - Fetch-stage predictor: a direct-mapped table of saturating counters (BHT), read combinationally to give a taken/not-taken guess.
  - Execute-stage resolver: decodes the branch opcode against the Z and S flags, updates the BHT, and issues a registered mispredict/redirect pulse.
- Sits between fetch (PC select) and execute (flag register); also keeps saturating performance counters.

---
 rtl/branch_predict_unit.sv | 148 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predict/resolve unit: fetch-side BHT lookup, execute-side resolution,
// BHT training, registered redirect pulse and saturating performance counters.
module branch_predict_unit #(
    parameter int OPC_W     = 6,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CTR_W     = 2,
    parameter int STAT_W    = 16,
    parameter bit EXT_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pf_valid,
    input  logic [PC_W-1:0]   pf_pc,
    input  logic [OPC_W-1:0]  pf_opcode,
    output logic              pf_taken,
    input  logic              rs_valid,
    input  logic [PC_W-1:0]   rs_pc,
    input  logic [OPC_W-1:0]  rs_opcode,
    input  logic              rs_pred,
    input  logic              flagZ,
    input  logic              flagS,
    output logic              br_valid,
    output logic              br_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    localparam logic [OPC_W-1:0] OP_BR  = OPC_W'(6'b001110);
    localparam logic [OPC_W-1:0] OP_BMI = OPC_W'(6'b001111);
    localparam logic [OPC_W-1:0] OP_BPL = OPC_W'(6'b010000);
    localparam logic [OPC_W-1:0] OP_BZ  = OPC_W'(6'b010001);
    localparam logic [OPC_W-1:0] OP_BNZ = OPC_W'(6'b010010);
    localparam logic [OPC_W-1:0] OP_BNM = OPC_W'(6'b010011);

    typedef enum logic [1:0] {K_NONE, K_ALWAYS, K_COND} br_kind_e;

    function automatic br_kind_e classify(input logic [OPC_W-1:0] opc);
        br_kind_e k;
        k = K_NONE;
        if (opc == OP_BR)
            k = K_ALWAYS;
        else if (opc == OP_BMI || opc == OP_BPL || opc == OP_BZ)
            k = K_COND;
        else if (EXT_EN && (opc == OP_BNZ || opc == OP_BNM))
            k = K_COND;
        return k;
    endfunction

    function automatic logic cond_taken(input logic [OPC_W-1:0] opc, input logic z, input logic s);
        logic t;
        t = 1'b0;
        if (opc == OP_BR)       t = 1'b1;
        else if (opc == OP_BMI) t = s;
        else if (opc == OP_BPL) t = ~s & ~z;
        else if (opc == OP_BZ)  t = z;
        else if (opc == OP_BNZ) t = ~z;
        else if (opc == OP_BNM) t = ~s;
        return t;
    endfunction

    logic [BHT_DEPTH-1:0][CTR_W-1:0] bht_q, bht_d;
    logic              br_valid_q, br_valid_d;
    logic              br_taken_q, br_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

    logic [IDX_W-1:0] pf_idx, rs_idx;
    br_kind_e         pf_kind, rs_kind;
    logic             rs_fire, rs_actual, rs_wrong;
    logic             z_g, s_g;
    logic             unused_pc;

    assign pf_idx    = pf_pc[IDX_W+1:2];
    assign rs_idx    = rs_pc[IDX_W+1:2];
    assign unused_pc = ^{pf_pc, rs_pc};

    // Fetch-side prediction: BR always taken, conditionals follow counter MSB
    always_comb begin
        pf_kind  = classify(pf_opcode);
        pf_taken = 1'b0;
        if (pf_valid) begin
            if (pf_kind == K_ALWAYS)    pf_taken = 1'b1;
            else if (pf_kind == K_COND) pf_taken = bht_q[pf_idx][CTR_W-1];
        end
    end

    // Resolve: flags gated by rs_valid so idle-cycle X never reaches state
    always_comb begin
        z_g       = flagZ & rs_valid;
        s_g       = flagS & rs_valid;
        rs_kind   = rs_valid ? classify(rs_opcode) : K_NONE;
        rs_fire   = (rs_kind != K_NONE);
        rs_actual = rs_fire & cond_taken(rs_opcode, z_g, s_g);
        rs_wrong  = rs_fire & (rs_actual != rs_pred);

        br_valid_d      = rs_fire;
        br_taken_d      = rs_actual;
        mispredict_d    = rs_wrong;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (rs_fire && stat_branches_q != '1) stat_branches_d = stat_branches_q + 1'b1;
        if (rs_wrong && stat_mispred_q != '1) stat_mispred_d = stat_mispred_q + 1'b1;
    end

    // BHT training: conditional branches only, saturating both ways
    always_comb begin
        bht_d = bht_q;
        if (rs_kind == K_COND) begin
            if (rs_actual) begin
                if (bht_q[rs_idx] != CTR_MAX) bht_d[rs_idx] = bht_q[rs_idx] + 1'b1;
            end else begin
                if (bht_q[rs_idx] != '0) bht_d[rs_idx] = bht_q[rs_idx] - 1'b1;
            end
        end
    end

    // State registers; reset drops any in-flight resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht_q           <= {BHT_DEPTH{CTR_INIT}};
            br_valid_q      <= 1'b0;
            br_taken_q      <= 1'b0;
            mispredict_q    <= 1'b0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            bht_q           <= bht_d;
            br_valid_q      <= br_valid_d;
            br_taken_q      <= br_taken_d;
            mispredict_q    <= mispredict_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign br_valid      = br_valid_q;
    assign br_taken      = br_taken_q;
    assign mispredict    = mispredict_q;
    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench: three DUT variants (default, EXT_EN=0, STAT_W=2) share one stimulus
// stream; an abstract per-variant model is compared every negedge, and
// directed literal checks pin the model to hand-computed values.
module tb_branch_predict_unit;
    localparam int N = 3;
    localparam logic [5:0] BR = 6'h0E, BMI = 6'h0F, BPL = 6'h10, BZ = 6'h11, BNZ = 6'h12, BNM = 6'h13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pf_valid, rs_valid, rs_pred, flagZ, flagS;
    logic [31:0] pf_pc, rs_pc;
    logic [5:0]  pf_opcode, rs_opcode;

    logic [N-1:0] pf_t, bv_o, bt_o, mp_o;
    logic [15:0]  sb0, sm0, sb1, sm1;
    logic [1:0]   sb2, sm2;
    logic [15:0]  sbo [N];
    logic [15:0]  smo [N];
    assign sbo[0] = sb0; assign smo[0] = sm0;
    assign sbo[1] = sb1; assign smo[1] = sm1;
    assign sbo[2] = {14'b0, sb2}; assign smo[2] = {14'b0, sm2};

    branch_predict_unit u0 (
        .clk(clk), .rst_n(rst_n), .pf_valid(pf_valid), .pf_pc(pf_pc), .pf_opcode(pf_opcode),
        .pf_taken(pf_t[0]), .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_opcode(rs_opcode),
        .rs_pred(rs_pred), .flagZ(flagZ), .flagS(flagS), .br_valid(bv_o[0]), .br_taken(bt_o[0]),
        .mispredict(mp_o[0]), .stat_branches(sb0), .stat_mispred(sm0));

    branch_predict_unit #(.EXT_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .pf_valid(pf_valid), .pf_pc(pf_pc), .pf_opcode(pf_opcode),
        .pf_taken(pf_t[1]), .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_opcode(rs_opcode),
        .rs_pred(rs_pred), .flagZ(flagZ), .flagS(flagS), .br_valid(bv_o[1]), .br_taken(bt_o[1]),
        .mispredict(mp_o[1]), .stat_branches(sb1), .stat_mispred(sm1));

    branch_predict_unit #(.STAT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .pf_valid(pf_valid), .pf_pc(pf_pc), .pf_opcode(pf_opcode),
        .pf_taken(pf_t[2]), .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_opcode(rs_opcode),
        .rs_pred(rs_pred), .flagZ(flagZ), .flagS(flagS), .br_valid(bv_o[2]), .br_taken(bt_o[2]),
        .mispredict(mp_o[2]), .stat_branches(sb2), .stat_mispred(sm2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit ext_en [N] = '{1'b1, 1'b0, 1'b1};
    int stat_max [N] = '{65535, 65535, 3};
    int bht [N][16];
    int m_sb [N];
    int m_sm [N];
    bit m_bv [N];
    bit m_bt [N];
    bit m_mp [N];

    // 0 = not a branch, 1 = unconditional, 2 = conditional
    function automatic int kind(input logic [5:0] opc, input bit e);
        if (opc == BR) return 1;
        if (opc == BMI || opc == BPL || opc == BZ) return 2;
        if (e && (opc == BNZ || opc == BNM)) return 2;
        return 0;
    endfunction

    function automatic bit outcome(input logic [5:0] opc, input bit z, input bit s);
        case (opc)
            BR:      return 1'b1;
            BMI:     return s;
            BPL:     return !s && !z;
            BZ:      return z;
            BNZ:     return !z;
            BNM:     return !s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit predict(input int i);
        int k;
        if (!pf_valid) return 1'b0;
        k = kind(pf_opcode, ext_en[i]);
        if (k == 1) return 1'b1;
        if (k == 2) return bht[i][(pf_pc >> 2) % 16] >= 2;
        return 1'b0;
    endfunction

    // model state advance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < 16; j++) bht[i][j] <= 1;
                m_sb[i] <= 0; m_sm[i] <= 0;
                m_bv[i] <= 1'b0; m_bt[i] <= 1'b0; m_mp[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int k, idx;
                bit t;
                k = rs_valid ? kind(rs_opcode, ext_en[i]) : 0;
                t = (k != 0) && outcome(rs_opcode, flagZ === 1'b1, flagS === 1'b1);
                idx = (rs_pc >> 2) % 16;
                m_bv[i] <= (k != 0);
                m_bt[i] <= t;
                m_mp[i] <= (k != 0) && (t != rs_pred);
                if (k != 0) begin
                    m_sb[i] <= (m_sb[i] + 1 > stat_max[i]) ? stat_max[i] : m_sb[i] + 1;
                    if (t != rs_pred)
                        m_sm[i] <= (m_sm[i] + 1 > stat_max[i]) ? stat_max[i] : m_sm[i] + 1;
                end
                if (k == 2)
                    bht[i][idx] <= t ? ((bht[i][idx] < 3) ? bht[i][idx] + 1 : 3)
                                     : ((bht[i][idx] > 0) ? bht[i][idx] - 1 : 0);
            end
        end
    end

    // compare process: every cycle, every variant
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("pf_taken[%0d]", i), 32'(pf_t[i]), 32'(predict(i)));
            chk($sformatf("br_valid[%0d]", i), 32'(bv_o[i]), 32'(m_bv[i]));
            chk($sformatf("br_taken[%0d]", i), 32'(bt_o[i]), 32'(m_bt[i]));
            chk($sformatf("mispredict[%0d]", i), 32'(mp_o[i]), 32'(m_mp[i]));
            chk($sformatf("stat_branches[%0d]", i), 32'(sbo[i]), 32'(m_sb[i]));
            chk($sformatf("stat_mispred[%0d]", i), 32'(smo[i]), 32'(m_sm[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rs_valid = 1'b0; rs_pc = '0; rs_opcode = '0; rs_pred = 1'b0;
        flagZ = 1'bx; flagS = 1'bx;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic [5:0] opc);
        pf_valid = v; pf_pc = pc; pf_opcode = opc;
    endtask

    task automatic resolve(input logic [5:0] opc, input logic [31:0] pc,
                           input logic z, input logic s, input logic pred);
        rs_valid = 1'b1; rs_opcode = opc; rs_pc = pc; flagZ = z; flagS = s; rs_pred = pred;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        fetch(1'b1, 32'h40, BR);
        repeat (2) @(posedge clk);
        #2;
        chk("br_in_reset", 32'(pf_t), 32'h7);
        rst_n = 1'b1;

        // reset state
        chk("rst_br_valid", 32'(bv_o), 32'h0);
        chk("rst_stat", 32'(sb0), 32'h0);
        fetch(1'b1, 32'h40, BZ); #1;
        chk("rst_pf_bz", 32'(pf_t[0]), 32'h0);

        // first BZ taken, predicted not-taken: 01 -> 10
        resolve(BZ, 32'h40, 1'b1, 1'b0, 1'b0); #1;
        chk("bz1_valid", 32'(bv_o[0]), 32'h1);
        chk("bz1_taken", 32'(bt_o[0]), 32'h1);
        chk("bz1_mispred", 32'(mp_o[0]), 32'h1);
        chk("bz1_pf", 32'(pf_t[0]), 32'h1);
        cyc(); #1;
        chk("bz1_pulse_end", 32'(mp_o[0]), 32'h0);

        // 10 -> 11 -> 11 (saturate) -> 10 on a not-taken: still predicts taken
        resolve(BZ, 32'h40, 1'b1, 1'b0, 1'b1); #1;
        chk("bz2_mispred", 32'(mp_o[0]), 32'h0);
        resolve(BZ, 32'h40, 1'b1, 1'b0, 1'b1);
        resolve(BZ, 32'h40, 1'b0, 1'b0, 1'b1); #1;
        chk("bz4_mispred", 32'(mp_o[0]), 32'h1);
        chk("bz4_taken", 32'(bt_o[0]), 32'h0);
        chk("sat_pf", 32'(pf_t[0]), 32'h1);
        chk("bz_stats_b", 32'(sb0), 32'd4);
        chk("bz_stats_m", 32'(sm0), 32'd2);

        // BR with unknown flags
        resolve(BR, 32'h44, 1'bx, 1'bx, 1'b1); #1;
        chk("br_taken", 32'(bt_o[0]), 32'h1);
        chk("br_mispred", 32'(mp_o[0]), 32'h0);
        fetch(1'b1, 32'h44, BZ); #1;
        chk("br_no_update", 32'(pf_t[0]), 32'h0);

        // 010010 is a branch only with the extension enabled
        fetch(1'b1, 32'h48, BNZ); #1;
        chk("ext0_pf", 32'(pf_t[1]), 32'h0);
        resolve(BNZ, 32'h48, 1'b0, 1'b0, 1'b0); #1;
        chk("ext1_bnz_valid", 32'(bv_o[0]), 32'h1);
        chk("ext0_bnz_valid", 32'(bv_o[1]), 32'h0);
        chk("ext0_stats", 32'(sb1), 32'd5);
        chk("ext1_stats", 32'(sb0), 32'd6);

        // BNM, S=0 -> taken
        resolve(BNM, 32'h4C, 1'b0, 1'b0, 1'b0); #1;
        chk("bnm_taken", 32'(bt_o[0]), 32'h1);
        chk("bnm_mispred", 32'(mp_o[0]), 32'h1);

        // asynchronous reset between edges with a resolution in flight
        resolve(BZ, 32'h40, 1'b1, 1'b0, 1'b0);
        rs_valid = 1'b1; rs_opcode = BZ; rs_pc = 32'h40; flagZ = 1'b1; flagS = 1'b0;
        fetch(1'b1, 32'h40, BZ); #1;
        rst_n = 1'b0; #1;
        chk("arst_valid", 32'(bv_o), 32'h0);
        chk("arst_taken", 32'(bt_o), 32'h0);
        chk("arst_mispred", 32'(mp_o), 32'h0);
        chk("arst_stats", 32'({sb0, sm0}), 32'h0);
        chk("arst_pf_bz", 32'(pf_t), 32'h0);
        fetch(1'b1, 32'h40, BR); #1;
        chk("arst_pf_br", 32'(pf_t), 32'h7);
        cyc();
        idle();
        rst_n = 1'b1; #1;
        chk("arst_discard", 32'(sb0), 32'h0);

        // same-cycle read and write of one entry: no bypass
        fetch(1'b1, 32'h80, BZ);
        rs_valid = 1'b1; rs_opcode = BZ; rs_pc = 32'h80; flagZ = 1'b1; flagS = 1'b0; rs_pred = 1'b0;
        #1;
        chk("same_cyc_pre", 32'(pf_t[0]), 32'h0);
        cyc();
        idle(); #1;
        chk("same_cyc_post", 32'(pf_t[0]), 32'h1);

        // a few more patterns: BMI / BPL
        fetch(1'b1, 32'h50, BMI);
        resolve(BMI, 32'h50, 1'b0, 1'b1, 1'b0); #1;
        chk("bmi_taken", 32'(bt_o[0]), 32'h1);
        resolve(BPL, 32'h54, 1'b1, 1'b0, 1'b1); #1;
        chk("bpl_taken", 32'(bt_o[0]), 32'h0);
        fetch(1'b0, 32'h54, BR); #1;
        chk("pf_invalid", 32'(pf_t[0]), 32'h0);

        // narrow stat counter saturation
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (5) resolve(BZ, 32'h90, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stat2_mispred", 32'(sm2), 32'd3);
        chk("stat2_branches", 32'(sb2), 32'd3);
        chk("stat16_mispred", 32'(sm0), 32'd5);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
